// File: rtl/sync_frame_pkg.sv
// Shared types, defaults and sizing helpers for the sync-pattern frame transmitter.
package sync_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SYNC = 3'd1,
        ST_DATA = 3'd2,
        ST_PAR  = 3'd3,
        ST_GAP  = 3'd4
    } state_e;

    localparam int unsigned SYNC_W_DEF    = 4;
    localparam logic [3:0]  SYNC_WORD_DEF = 4'b1101;

    // Frame length in line cycles: sync word, payload, optional parity bit.
    function automatic int unsigned frame_len(input int unsigned data_w,
                                              input int unsigned sync_w,
                                              input bit          parity_en);
        return sync_w + data_w + (parity_en ? 32'd1 : 32'd0);
    endfunction

    // Counter width large enough to hold the longest per-state count.
    function automatic int unsigned cnt_w(input int unsigned a,
                                          input int unsigned b,
                                          input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 1) ? 32'd1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/sync_frame_shreg.sv
// Loadable MSB-first shift register with a down-counter of bits still to be emitted.
module sync_frame_shreg #(
    parameter int unsigned W        = 8,
    parameter int unsigned CW       = 4,
    parameter int unsigned LOAD_CNT = W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         shift_i,
    output logic         ser_o,
    output logic         zero_o,
    output logic         last_o
);

    logic [W-1:0]  sh_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q  <= '0;
            cnt_q <= '0;
        end else if (load_i) begin
            sh_q  <= load_val_i;
            cnt_q <= CW'(LOAD_CNT);
        end else if (shift_i && (cnt_q != '0)) begin
            sh_q  <= sh_q << 1;
            cnt_q <= cnt_q - CW'(1);
        end
    end

    assign ser_o  = sh_q[W-1];
    assign zero_o = (cnt_q == '0);
    assign last_o = (cnt_q == CW'(1));

endmodule

// File: rtl/sync_frame_tx.sv
// Serial frame transmitter: sync word, payload MSB first, optional even parity, idle gap.
// Parity bit is built only when SYNC_FRAME_TX_PARITY_EN is defined.
module sync_frame_tx
    import sync_frame_pkg::*;
#(
    parameter int unsigned       DATA_W    = 8,
    parameter int unsigned       SYNC_W    = SYNC_W_DEF,
    parameter logic [SYNC_W-1:0] SYNC_WORD = SYNC_W'(SYNC_WORD_DEF),
    parameter int unsigned       IDLE_GAP  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic              tx_bit_o,
    output logic              tx_en_o,
    output logic              busy_o,
    output logic              frame_done_o
);

    localparam int unsigned     CNT_W    = cnt_w(SYNC_W, DATA_W, IDLE_GAP);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'((IDLE_GAP > 0) ? IDLE_GAP - 1 : 0);

    state_e           state_q;
    logic [CNT_W-1:0] gap_cnt_q;
    logic             in_ready_q, tx_bit_q, tx_en_q, busy_q, frame_done_q;

    logic hs_c, sync_shift_c, data_shift_c, frame_end_c;
    logic sync_ser, sync_zero, sync_last_unused;
    logic data_ser, data_zero, data_last;

    assign hs_c         = (state_q == ST_IDLE) && in_valid_i && in_ready_q;
    assign sync_shift_c = (state_q == ST_SYNC) && !sync_zero;
    assign data_shift_c = ((state_q == ST_SYNC) && sync_zero) ||
                          ((state_q == ST_DATA) && !data_zero);

    // The sync MSB goes straight to the line at the handshake, so the register holds the rest.
    sync_frame_shreg #(.W(SYNC_W), .CW(CNT_W), .LOAD_CNT(SYNC_W - 1)) u_sync (
        .clk        (clk),
        .rst        (rst),
        .load_i     (hs_c),
        .load_val_i (SYNC_W'(SYNC_WORD << 1)),
        .shift_i    (sync_shift_c),
        .ser_o      (sync_ser),
        .zero_o     (sync_zero),
        .last_o     (sync_last_unused)
    );

    sync_frame_shreg #(.W(DATA_W), .CW(CNT_W), .LOAD_CNT(DATA_W)) u_data (
        .clk        (clk),
        .rst        (rst),
        .load_i     (hs_c),
        .load_val_i (in_data_i),
        .shift_i    (data_shift_c),
        .ser_o      (data_ser),
        .zero_o     (data_zero),
        .last_o     (data_last)
    );

`ifdef SYNC_FRAME_TX_PARITY_EN
    logic par_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       par_q <= 1'b0;
        else if (hs_c) par_q <= ^in_data_i;
    end

    assign frame_end_c = (state_q == ST_PAR);
`else
    assign frame_end_c = (state_q == ST_DATA) && data_zero;
`endif

    // Each edge decides which bit sits on the line during the following cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            gap_cnt_q    <= '0;
            in_ready_q   <= 1'b0;
            tx_bit_q     <= 1'b0;
            tx_en_q      <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            if (frame_end_c) begin
                tx_bit_q <= 1'b0;
                tx_en_q  <= 1'b0;
                if (IDLE_GAP > 0) begin
                    state_q   <= ST_GAP;
                    gap_cnt_q <= GAP_LOAD;
                end else begin
                    state_q    <= ST_IDLE;
                    busy_q     <= 1'b0;
                    in_ready_q <= 1'b1;
                end
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (hs_c) begin
                            state_q    <= ST_SYNC;
                            tx_bit_q   <= SYNC_WORD[SYNC_W-1];
                            tx_en_q    <= 1'b1;
                            busy_q     <= 1'b1;
                            in_ready_q <= 1'b0;
                        end else begin
                            in_ready_q <= 1'b1;
                        end
                    end
                    ST_SYNC: begin
                        if (!sync_zero) begin
                            tx_bit_q <= sync_ser;
                        end else begin
                            state_q  <= ST_DATA;
                            tx_bit_q <= data_ser;
`ifndef SYNC_FRAME_TX_PARITY_EN
                            frame_done_q <= data_last;
`endif
                        end
                    end
                    ST_DATA: begin
`ifdef SYNC_FRAME_TX_PARITY_EN
                        if (data_zero) begin
                            state_q      <= ST_PAR;
                            tx_bit_q     <= par_q;
                            frame_done_q <= 1'b1;
                        end else begin
                            tx_bit_q <= data_ser;
                        end
`else
                        tx_bit_q     <= data_ser;
                        frame_done_q <= data_last;
`endif
                    end
                    ST_GAP: begin
                        if (gap_cnt_q == '0) begin
                            state_q    <= ST_IDLE;
                            busy_q     <= 1'b0;
                            in_ready_q <= 1'b1;
                        end else begin
                            gap_cnt_q <= gap_cnt_q - CNT_W'(1);
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign in_ready_o   = in_ready_q;
    assign tx_bit_o     = tx_bit_q;
    assign tx_en_o      = tx_en_q;
    assign busy_o       = busy_q;
    assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_sync_frame_tx.sv
// Bench for sync_frame_tx: two instances (IDLE_GAP=1 and IDLE_GAP=0) against a cycle-index frame model.
module tb_sync_frame_tx;

    localparam int unsigned DW = 8;
    localparam int unsigned SW = 4;
`ifdef SYNC_FRAME_TX_PARITY_EN
    localparam int unsigned PB = 1;
    localparam logic [31:0] LIT_DIR   = 32'b1101_1010_0101_0;   // 0xA5
    localparam logic [31:0] LIT_0F    = 32'b1101_0000_1111_0;
    localparam logic [31:0] LIT_F0    = 32'b1101_1111_0000_0;
    localparam logic [31:0] LIT_81    = 32'b1101_1000_0001_0;
    localparam logic [7:0]  DIR_WORD  = 8'hA5;
    localparam int          DONE_IDX  = 13;
    localparam int          RDY_IDX   = 15;
    localparam int          PERIOD_G1 = 15;
    localparam int          PERIOD_G0 = 14;
`else
    localparam int unsigned PB = 0;
    localparam logic [31:0] LIT_DIR   = 32'b1101_0011_1100;     // 0x3C
    localparam logic [31:0] LIT_0F    = 32'b1101_0000_1111;
    localparam logic [31:0] LIT_F0    = 32'b1101_1111_0000;
    localparam logic [31:0] LIT_81    = 32'b1101_1000_0001;
    localparam logic [7:0]  DIR_WORD  = 8'h3C;
    localparam int          DONE_IDX  = 12;
    localparam int          RDY_IDX   = 14;
    localparam int          PERIOD_G1 = 14;
    localparam int          PERIOD_G0 = 13;
`endif
    localparam int L = int'(SW + DW + PB);

    logic clk = 1'b0;
    logic rst;
    logic vld0, vld1;
    logic [DW-1:0] dat0, dat1;
    logic rdy0, txb0, txe0, bsy0, fd0;
    logic rdy1, txb1, txe1, bsy1, fd1;
    logic [4:0] obs [2];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int k [2] = '{-1, -1};
    int dut_hs [2] = '{-1, -1};
    int dut_hs_prev [2] = '{-1, -1};
    logic [L-1:0] fr [2];

    always #5 clk = ~clk;

    sync_frame_tx #(.DATA_W(DW), .IDLE_GAP(1)) dut0 (
        .clk(clk), .rst(rst), .in_data_i(dat0), .in_valid_i(vld0), .in_ready_o(rdy0),
        .tx_bit_o(txb0), .tx_en_o(txe0), .busy_o(bsy0), .frame_done_o(fd0));

    sync_frame_tx #(.DATA_W(DW), .IDLE_GAP(0)) dut1 (
        .clk(clk), .rst(rst), .in_data_i(dat1), .in_valid_i(vld1), .in_ready_o(rdy1),
        .tx_bit_o(txb1), .tx_en_o(txe1), .busy_o(bsy1), .frame_done_o(fd1));

    assign obs[0] = {rdy0, txb0, txe0, bsy0, fd0};
    assign obs[1] = {rdy1, txb1, txe1, bsy1, fd1};

    function automatic logic [L-1:0] build(input logic [DW-1:0] d);
`ifdef SYNC_FRAME_TX_PARITY_EN
        return {4'b1101, d, ^d};
`else
        return {4'b1101, d};
`endif
    endfunction

    function automatic int gap_of(input int i);
        return (i == 0) ? 1 : 0;
    endfunction

    // k: -1 just out of reset, 0 idle, else cycles since the accepted handshake.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                k[i] = -1;
                dut_hs[i] = -1;
                dut_hs_prev[i] = -1;
            end
        end else begin
            cyc++;
            if (vld0 && rdy0) begin dut_hs_prev[0] = dut_hs[0]; dut_hs[0] = cyc; end
            if (vld1 && rdy1) begin
                if (dut_hs[1] >= 0) begin
                    vectors++;
                    if (cyc - dut_hs[1] != PERIOD_G0) begin
                        miscompares++;
                        $display("FAIL gap0_period: got %0d cycles, want %0d", cyc - dut_hs[1], PERIOD_G0);
                    end
                end
                dut_hs[1] = cyc;
            end
            for (int i = 0; i < 2; i++) begin
                if (k[i] < 0) begin
                    k[i] = 0;
                end else if (k[i] == 0) begin
                    if ((i == 0) ? vld0 : vld1) begin
                        fr[i] = build((i == 0) ? dat0 : dat1);
                        k[i] = 1;
                    end
                end else begin
                    k[i]++;
                    if (k[i] > L + gap_of(i)) k[i] = 0;
                end
            end
        end
    end

    function automatic logic [4:0] expect_o(input int i);
        if (k[i] < 0)  return 5'b00000;
        if (k[i] == 0) return 5'b10000;
        if (k[i] <= L) return {1'b0, fr[i][L - k[i]], 1'b1, 1'b1, k[i] == L};
        return 5'b00010;
    endfunction

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic [4:0] e;
            e = expect_o(i);
            vectors++;
            if (obs[i] !== e) begin
                miscompares++;
                $display("FAIL cycle_check inst%0d cyc=%0d k=%0d: got rdy/tx/en/busy/done=%b want %b",
                         i, cyc, k[i], obs[i], e);
            end
        end
    end

    always @(negedge clk) dat1 = DW'($urandom);

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (k[0] != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (k[0] != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_idle: model idle not reached within 100 cycles");
        end
    endtask

    // Called at a negedge with the handshake set up; samples cycles 1..L+2.
    task automatic collect(input logic hold, input logic [DW-1:0] next_w,
                           output logic [31:0] bits, output int done_idx, output int rdy_idx);
        bits = '0;
        done_idx = 0;
        rdy_idx = 0;
        for (int i = 1; i <= L + 2; i++) begin
            @(negedge clk);
            if (!hold) vld0 = 1'b0;
            dat0 = (i >= L + 1) ? next_w : DW'($urandom);
            if (i <= L) bits[L - i] = txb0;
            if (fd0 && done_idx == 0) done_idx = i;
            if (rdy0 && rdy_idx == 0) rdy_idx = i;
        end
    endtask

    task automatic reset_pulse(input string name);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check(name, 32'(obs[0]), 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
    endtask

    initial begin
        logic [31:0] bits;
        int d_idx, r_idx;
        rst = 1'b1; vld0 = 1'b0; dat0 = '0; vld1 = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("ready_after_release", 32'(rdy0), 32'd1);
        reset_pulse("async_reset_idle");

        wait_idle();
        vld0 = 1'b1; dat0 = DIR_WORD;
        collect(1'b0, '0, bits, d_idx, r_idx);
        check("directed_bits", bits, LIT_DIR);
        check("directed_done_cycle", 32'(d_idx), 32'(DONE_IDX));
        check("directed_ready_cycle", 32'(r_idx), 32'(RDY_IDX));

        wait_idle();
        vld0 = 1'b1; dat0 = 8'h0F;
        collect(1'b1, 8'hF0, bits, d_idx, r_idx);
        check("b2b_first_bits", bits, LIT_0F);
        collect(1'b0, '0, bits, d_idx, r_idx);
        check("b2b_second_bits", bits, LIT_F0);
        check("b2b_period", 32'(dut_hs[0] - dut_hs_prev[0]), 32'(PERIOD_G1));

        wait_idle();
        vld0 = 1'b1; dat0 = DW'($urandom);
        @(negedge clk);
        vld0 = 1'b0;
        repeat (6) @(negedge clk);
        check("midframe_txen_before_reset", 32'(txe0), 32'd1);
        reset_pulse("async_reset_midframe");
        wait_idle();
        vld0 = 1'b1; dat0 = 8'h81;
        collect(1'b0, '0, bits, d_idx, r_idx);
        check("post_reset_bits", bits, LIT_81);
        check("post_reset_done_cycle", 32'(d_idx), 32'(DONE_IDX));

        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            vld0 = 1'($urandom_range(0, 1));
            dat0 = DW'($urandom);
        end
        vld0 = 1'b0;
        repeat (20) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sync_frame_tx.md
# sync_frame_tx

- Serial frame transmitter; the sending end of the team's serial sync-pattern link.
- Accepts one DATA_W-bit word per valid/ready handshake.
- Emits on a single wire, MSB first: the sync word, then the payload, then an optional parity bit, then a forced-low idle gap.
- The framing lets the team's downstream 1101 sequence detectors lock onto frame starts.

## Interface

Parameters:
- DATA_W, 8, payload width in bits (≥1)
- SYNC_W, 4, sync word width
- SYNC_WORD, 4'b1101, sync pattern, transmitted MSB first
- IDLE_GAP, 1, forced idle cycles after each frame (0..15)

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  reset, asynchronous, active-high
- in_data  input  DATA_W  payload word, sampled on handshake
- in_valid  input  1  upstream word available
- in_ready  output  1  block can accept a word (registered)
- tx_bit  output  1  serial line (registered); 0 when not transmitting
- tx_en  output  1  high while tx_bit carries a frame bit (registered)
- busy  output  1  high from handshake until return to IDLE
- frame_done  output  1  one-cycle pulse coincident with the last frame bit

## Operation

- States: IDLE, SYNC, DATA, PAR (PAR exists only with the macro), GAP.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready at a rising edge: capture in_data into the shift register, go to SYNC, clear in_ready.
- SYNC: SYNC_W cycles, tx_bit = SYNC_WORD[SYNC_W-1] down to [0]. Then DATA.
- DATA: DATA_W cycles, tx_bit = captured word MSB first.
- PAR: 1 cycle, tx_bit = even parity, the XOR of the captured word.
- After the last frame bit:
  - If IDLE_GAP>0, go to GAP: IDLE_GAP cycles with tx_bit=0, tx_en=0, busy=1.
  - If IDLE_GAP=0, go directly to IDLE.
- in_ready is registered as (next_state==IDLE):
  - It is 0 during every frame and gap cycle.
  - It returns to 1 in the cycle the state becomes IDLE.
- in_valid and in_data are ignored outside IDLE. Changes to in_data mid-frame do not affect the frame, because the word is captured at the handshake.
- Bit counter width: $clog2(max(SYNC_W, DATA_W, IDLE_GAP)+1). The counter reloads at every state entry and never wraps inside a state.
- Reset values: state=IDLE, in_ready=0, tx_bit=0, tx_en=0, busy=0, frame_done=0, shift register=0.
- Reset mid-frame:
  - All outputs go to their reset values asynchronously.
  - The frame is abandoned and the word is discarded; there is no partial completion and no frame_done.
- in_ready rises at the first rising edge after rst deasserts.

## Timing

- Cycle 0 is the cycle whose closing edge samples the handshake.
- Frame bit i (i=0 is the sync MSB) is driven in cycle i+1, with tx_en=1 and busy=1.
- Frame length L = SYNC_W + DATA_W + P, where P=1 if parity is enabled, else 0.
- The last bit is in cycle L; frame_done=1 in cycle L only.
- Gap occupies cycles L+1 .. L+IDLE_GAP.
- IDLE, with in_ready=1, is reached in cycle L+IDLE_GAP+1.
- Earliest next handshake: at the close of cycle L+IDLE_GAP+1.
- Minimum frame-to-frame period: L+IDLE_GAP+1 cycles.
- in_valid held continuously high gives exactly that period.
- The line is never driven by a combinational path from in_data or in_valid.

## Configuration

- Macro: SYNC_FRAME_TX_PARITY_EN.
- Defined: the PAR state exists, L = SYNC_W+DATA_W+1, and the even parity bit follows the payload.
- Undefined: PAR is not compiled, L = SYNC_W+DATA_W, DATA goes straight to GAP/IDLE, and there is no parity logic.

## Structure

- Package sync_frame_pkg holds:
  - the state enum (IDLE, SYNC, DATA, PAR, GAP), 3-bit encoding
  - the SYNC_W and SYNC_WORD defaults
  - a function computing L from DATA_W and the parity setting
- One sub-module: sync_frame_shreg.
  - Function: loadable MSB-first shift register plus down-counter.
  - Inputs: load value, load strobe, shift enable.
  - Outputs: serial out, count==0 flag.
  - The top-level FSM uses one instance for the sync word and one for the payload.

## Test plan

1. Reset: assert rst mid-idle -> all outputs 0 immediately. Release -> in_ready=1 after the first edge, tx_bit=0.
2. Parity enabled, DATA_W=8, send 0xA5, IDLE_GAP=1:
   - tx_bit in cycles 1..13 = 1101 10100101 0.
   - tx_en high in cycles 1..13; frame_done pulses in cycle 13.
   - Gap in cycle 14; in_ready=1 in cycle 15.
3. Parity disabled, send 0x3C -> cycles 1..12 = 1101 00111100, frame_done in cycle 12, in_ready=1 in cycle 14.
4. Back-to-back: in_valid held high with 0x0F then 0xF0 -> second handshake exactly at the cycle-15 edge (parity on). Gap cycle tx_bit=0. Second frame bits are correct, and in_data changes during frame 1 have no effect.
5. Reset mid-frame at payload bit 3 -> tx_en/tx_bit/busy drop to 0 asynchronously, and there is no frame_done. After release, a fresh 0x81 frame is transmitted fully and correctly.
6. IDLE_GAP=0, parity on, continuous valid -> frames every 14 cycles, and no 0-gap cycle between frame_done and the next sync bit beyond the single IDLE cycle.
